// File: rtl/two_req_arbiter_if.sv
// Request/grant bundle between two requesters and the shared-resource arbiter.
interface two_req_arbiter_if;
   logic req_0;
   logic req_1;
   logic gnt_0;
   logic gnt_1;

   modport master (output req_0, output req_1, input gnt_0, input gnt_1);
   modport slave  (input req_0, input req_1, output gnt_0, output gnt_1);
endinterface

// File: rtl/two_req_arbiter.sv
// Two-requester Moore arbiter: fixed-priority or round-robin tie-break, optional
// hold limit that forces a handover when the other requester has waited too long.
module two_req_arbiter #(
   parameter int unsigned RR_MODE  = 0,
   parameter int unsigned MAX_HOLD = 0,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   two_req_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam bit              RR        = (RR_MODE != 0);
   localparam bit              HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             last;
   logic             last_nxt;
   logic             other_req;
   logic             hold_hit;

   // Next-state, hold counter and last-granted update
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      hold_hit  = HOLD_EN && (cnt == HOLD_LAST);
      other_req = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.req_0 && bus.req_1) begin
               state_nxt = (RR && !last) ? GNT1 : GNT0;
            end else if (bus.req_0) begin
               state_nxt = GNT0;
            end else if (bus.req_1) begin
               state_nxt = GNT1;
            end
         end
         GNT0: begin
            other_req = bus.req_1;
            if (!bus.req_0) begin
               state_nxt = bus.req_1 ? GNT1 : IDLE;
            end else if (bus.req_1 && hold_hit) begin
               state_nxt = GNT1;
            end
         end
         GNT1: begin
            other_req = bus.req_0;
            if (!bus.req_1) begin
               state_nxt = bus.req_0 ? GNT0 : IDLE;
            end else if (bus.req_0 && hold_hit) begin
               state_nxt = GNT0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Entry into a grant state restarts the hold count; otherwise count waiting cycles
      if ((state_nxt != state) && (state_nxt != IDLE)) begin
         cnt_nxt  = '0;
         last_nxt = (state_nxt == GNT1);
      end else if ((state_nxt == state) && other_req && (cnt != CNT_MAX)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // State and grant flops; grants mirror the registered next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         bus.gnt_0 <= 1'b0;
         bus.gnt_1 <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
         bus.gnt_0 <= (state_nxt == GNT0);
         bus.gnt_1 <= (state_nxt == GNT1);
      end
   end

endmodule

// File: tb/tb_two_req_arbiter.sv
// Drives four arbiter configurations with shared requests; checks a directed
// vector table, hand-written corner sequences and random traffic against a model.
module tb_two_req_arbiter;

   localparam int NDUT = 4;
   localparam int RR_CFG [NDUT] = '{0, 1, 0, 1};
   localparam int MH_CFG [NDUT] = '{0, 0, 4, 2};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   two_req_arbiter_if bus_fp ();
   two_req_arbiter_if bus_rr ();
   two_req_arbiter_if bus_hl ();
   two_req_arbiter_if bus_rh ();

   two_req_arbiter #(.RR_MODE(0), .MAX_HOLD(0), .CNT_W(8)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp));
   two_req_arbiter #(.RR_MODE(1), .MAX_HOLD(0), .CNT_W(8)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr));
   two_req_arbiter #(.RR_MODE(0), .MAX_HOLD(4), .CNT_W(8)) u_hl (.clk(clk), .rst(rst), .bus(bus_hl));
   two_req_arbiter #(.RR_MODE(1), .MAX_HOLD(2), .CNT_W(3)) u_rh (.clk(clk), .rst(rst), .bus(bus_rh));

   logic [1:0] g [NDUT];
   assign g[0] = {bus_fp.gnt_1, bus_fp.gnt_0};
   assign g[1] = {bus_rr.gnt_1, bus_rr.gnt_0};
   assign g[2] = {bus_hl.gnt_1, bus_hl.gnt_0};
   assign g[3] = {bus_rh.gnt_1, bus_rh.gnt_0};

   typedef struct {
      logic       r0;
      logic       r1;
      logic [1:0] e_fp;
      logic [1:0] e_rr;
      logic [1:0] e_hl;
   } vec_t;

   vec_t vecs [17];

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource (-1 none), how long the other side waited
   int owner [NDUT];
   int waited [NDUT];
   int last [NDUT];

   function automatic void model_reset();
      for (int k = 0; k < NDUT; k++) begin
         owner[k]  = -1;
         waited[k] = 0;
         last[k]   = 1;
      end
   endfunction

   function automatic void model_step(input int k, input bit r0, input bit r1);
      bit want [2];
      int nxt;
      int o;
      want[0] = r0;
      want[1] = r1;
      o = owner[k];
      if (o < 0) begin
         if (r0 && r1)  nxt = (RR_CFG[k] != 0) ? 1 - last[k] : 0;
         else if (r0)   nxt = 0;
         else if (r1)   nxt = 1;
         else           nxt = -1;
      end else if (!want[o]) begin
         nxt = want[1-o] ? 1 - o : -1;
      end else if (want[1-o] && MH_CFG[k] > 0 && waited[k] + 1 >= MH_CFG[k]) begin
         nxt = 1 - o;
      end else begin
         nxt = o;
      end
      if (nxt >= 0 && nxt != o) begin
         waited[k] = 0;
         last[k]   = nxt;
      end else if (nxt >= 0 && want[1-nxt]) begin
         waited[k] = waited[k] + 1;
      end
      owner[k] = nxt;
   endfunction

   function automatic logic [1:0] model_gnt(input int k);
      if (owner[k] == 0) return 2'b01;
      if (owner[k] == 1) return 2'b10;
      return 2'b00;
   endfunction

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("model dut%0d", k), g[k], model_gnt(k));
         check($sformatf("exclusive dut%0d", k), {1'b0, g[k][1] & g[k][0]}, 2'b00);
      end
   endtask

   task automatic drive(input logic r0, input logic r1);
      bus_fp.req_0 = r0; bus_fp.req_1 = r1;
      bus_rr.req_0 = r0; bus_rr.req_1 = r1;
      bus_hl.req_0 = r0; bus_hl.req_1 = r1;
      bus_rh.req_0 = r0; bus_rh.req_1 = r1;
   endtask

   task automatic tick(input logic r0, input logic r1);
      drive(r0, r1);
      @(posedge clk);
      for (int k = 0; k < NDUT; k++) model_step(k, r0, r1);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      vecs[1]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01};
      vecs[2]  = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b01};
      vecs[3]  = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b01};
      vecs[4]  = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b01};
      vecs[5]  = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b10};
      vecs[6]  = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b10};
      vecs[7]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      vecs[8]  = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b01};
      vecs[9]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      vecs[10] = '{1'b1, 1'b1, 2'b01, 2'b10, 2'b01};
      vecs[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      vecs[12] = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b01};
      vecs[13] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b10};
      vecs[14] = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b10};
      vecs[15] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01};
      vecs[16] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00};

      // Reset held with both requests up: grants stay low, first edge after release grants 0
      rst = 1'b0;
      drive(1'b1, 1'b1);
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NDUT; k++) check($sformatf("reset hold dut%0d", k), g[k], 2'b00);
      end
      #2 rst = 1'b1;
      tick(1'b1, 1'b1);
      for (int k = 0; k < NDUT; k++) check($sformatf("post reset dut%0d", k), g[k], 2'b01);

      // Directed vector table from a fresh reset
      do_reset();
      for (int i = 0; i < 17; i++) begin
         tick(vecs[i].r0, vecs[i].r1);
         check($sformatf("vec%0d fp", i), g[0], vecs[i].e_fp);
         check($sformatf("vec%0d rr", i), g[1], vecs[i].e_rr);
         check($sformatf("vec%0d hl", i), g[2], vecs[i].e_hl);
      end

      // Handover with no idle bubble when the holder drops
      do_reset();
      tick(1'b1, 1'b0);
      check("handover grant0", g[0], 2'b01);
      repeat (3) begin
         tick(1'b1, 1'b1);
         check("handover hold0", g[0], 2'b01);
      end
      tick(1'b0, 1'b1);
      check("handover direct", g[0], 2'b10);

      // Continuous contention with hold limit 4: alternate every 4 grant cycles
      do_reset();
      for (int c = 0; c < 16; c++) begin
         tick(1'b1, 1'b1);
         check($sformatf("hold4 cyc%0d", c), g[2], ((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Asynchronous reset between edges while granted to requester 1
      do_reset();
      tick(1'b0, 1'b1);
      check("pre async gnt1", g[0], 2'b10);
      @(negedge clk);
      #1 rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < NDUT; k++) check($sformatf("async drop dut%0d", k), g[k], 2'b00);
      @(posedge clk);
      #1 rst = 1'b1;
      tick(1'b1, 1'b1);
      for (int k = 0; k < NDUT; k++) check($sformatf("async restart dut%0d", k), g[k], 2'b01);

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         tick(($urandom % 4) != 0, ($urandom % 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/two_req_arbiter.md
Name: two_req_arbiter

Overview:
- Two-requester grant arbiter built as a small Moore state machine with registered, mutually exclusive grant outputs.
- Sits in front of a shared resource (bus, memory port) and grants exactly one of two requesters at a time.
- A grant is held while its request stays asserted, unless the optional hold limit forces a handover.
- Arbitration is fixed priority (req_0 wins) or round-robin, selected by parameter.

Parameters:
- RR_MODE, 0, 0 = fixed priority (req_0 wins ties); 1 = round-robin (the requester not granted most recently wins ties).
- MAX_HOLD, 0, maximum consecutive grant cycles while the other requester waits; 0 = unlimited (hold until request drops).
- CNT_W, 8, width of the hold counter; MAX_HOLD must be < 2^CNT_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_0  input  1  request from requester 0; level-sensitive.
- req_1  input  1  request from requester 1; level-sensitive.
- gnt_0  output  1  grant to requester 0; registered.
- gnt_1  output  1  grant to requester 1; registered.

Behaviour:
- Reset:
  - rst=0 immediately forces state IDLE, gnt_0=0, gnt_1=0, hold counter=0 and last-granted=1 (so requester 0 wins the first round-robin tie).
  - Reset asserted mid-grant drops the grant asynchronously, without waiting for a clock edge.
  - Deassertion of rst takes effect at the next rising edge.
- States: IDLE, GNT0, GNT1, encoded one-hot or binary.
  - gnt_0 = (state==GNT0) and gnt_1 = (state==GNT1), both driven from flops.
  - gnt_0 and gnt_1 are never both 1.
- Latency: a request sampled high at edge N produces its grant after edge N, i.e. one clock of latency. A request dropped at edge N removes its grant after edge N.
- IDLE:
  - Neither request -> stay IDLE.
  - Only req_0 -> GNT0; only req_1 -> GNT1.
  - Both requests: RR_MODE=0 -> GNT0. RR_MODE=1 -> grant the requester that was not granted last.
- GNT0:
  - req_0=1 and no forced handover -> stay GNT0.
  - req_0=0 and req_1=1 -> GNT1 directly, with no IDLE bubble.
  - req_0=0 and req_1=0 -> IDLE.
- GNT1: symmetric to GNT0.
  - In RR_MODE=0, req_0 does not preempt an active GNT1; req_0 waits until req_1 drops or the hold limit is reached.
- Hold limit (MAX_HOLD>0):
  - The counter clears on entry to a grant state and increments each cycle the grant is held while the other request is asserted.
  - When the count reaches MAX_HOLD-1 with the other request still asserted, the next state is the other grant state.
  - The counter saturates and never wraps. It does not count while the other request is low.
- Last-granted register: updated on every entry to GNT0 or GNT1. It is used only when RR_MODE=1.
- No combinational path from the req inputs to the gnt outputs.
- X on a req input is not a legal input condition; the bench must drive only 0 or 1.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_0=req_1=1 -> gnt_0=0 and gnt_1=0 throughout; after rst=1, the first edge gives gnt_0=1 (both modes).
- Single request: req_0=1 at edge N -> gnt_0=1 after edge N. req_0=0 at edge M -> gnt_0=0 after edge M and state returns to IDLE. Same check for req_1/gnt_1.
- Handover: req_0=1 and granted, then req_1=1 for 3 cycles, then req_0=0 -> gnt_0 holds until the drop, and gnt_1=1 on the very next edge with no idle cycle.
- Simultaneous requests, RR_MODE=0: req_0=req_1=1 from IDLE -> gnt_0=1; repeating from IDLE again gives gnt_0 again. RR_MODE=1 -> grants alternate gnt_0, gnt_1, gnt_0 across successive IDLE ties.
- Hold limit, MAX_HOLD=4: req_0 and req_1 both continuously 1 -> gnt_0 for 4 cycles, then gnt_1 for 4 cycles, alternating. Check gnt_0 and gnt_1 are never simultaneously 1.
- Async reset mid-grant: gnt_1=1, then rst falls between clock edges -> gnt_1 goes to 0 before the next edge; after rst rises, arbitration restarts from IDLE.
